// File: rtl/vga_frame_reader_pkg.sv
// Constants shared by the frame-buffer painter and reader: frame-buffer geometry,
// the pixel-to-address mapping, the palette and 640x480@60 VGA timing.
`define MAP_PIXELCO_MEMADDR(x, y) ({(y), (x)})

package vga_frame_reader_pkg;

  localparam int SCR_WIDTH        = 128;
  localparam int SCR_HEIGHT       = 96;
  localparam int MEMORY_SIZE_BITS = 14;

  localparam logic [2:0] COLOR_BLACK  = 3'b000;
  localparam logic [2:0] COLOR_BLUE   = 3'b001;
  localparam logic [2:0] COLOR_YELLOW = 3'b110;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The x4-scaled frame buffer sits centred in the active area.
  localparam int SCALE_SHIFT = 2;
  localparam int WIN_X0      = 64;
  localparam int WIN_Y0      = 48;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate phase, h/v scan counters and raw active/sync flags for 640x480@60.
module vga_timing_gen
  import vga_frame_reader_pkg::*;
(
  input  logic   Clck,
  input  logic   Reset,
  output logic   phase,
  output coord_t h,
  output coord_t v,
  output logic   active,
  output logic   hsync_on,
  output logic   vsync_on
);

  // Counters step only on the second Clck of each pixel, giving 25 MHz pixels.
  always_ff @(posedge Clck) begin
    if (Reset) begin
      phase <= 1'b0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h == coord_t'(H_TOTAL - 1)) begin
          h <= '0;
          v <= (v == coord_t'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign active   = (h < coord_t'(H_ACTIVE)) && (v < coord_t'(V_ACTIVE));
  assign hsync_on = (h >= coord_t'(H_ACTIVE + H_FP)) &&
                    (h <  coord_t'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_on = (v >= coord_t'(V_ACTIVE + V_FP)) &&
                    (v <  coord_t'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out: maps VGA position to a x4-scaled window address and
// drives sync/blank/colour through a two-stage pipeline aligned with mem_q.
module vga_frame_reader #(
  parameter int         SCR_WIDTH        = 128,
  parameter int         SCR_HEIGHT       = 96,
  parameter int         MEMORY_SIZE_BITS = 14,
  parameter logic [2:0] BORDER_COLOR     = 3'b000
) (
  input  logic                        Clck,
  input  logic                        Reset,
  output logic [MEMORY_SIZE_BITS-1:0] mem_address,
  input  logic [2:0]                  mem_q,
  output logic [2:0]                  vga_color,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        vga_blank_n,
  output logic                        frame_done
);
  import vga_frame_reader_pkg::*;

  localparam int XB = $clog2(SCR_WIDTH);
  localparam int YB = $clog2(SCR_HEIGHT);

  logic   phase, active_raw, hsync_raw, vsync_raw;
  coord_t h, v;

  vga_timing_gen u_timing (
    .Clck     (Clck),
    .Reset    (Reset),
    .phase    (phase),
    .h        (h),
    .v        (v),
    .active   (active_raw),
    .hsync_on (hsync_raw),
    .vsync_on (vsync_raw)
  );

  logic          in_win;
  logic [XB-1:0] fb_x;
  logic [YB-1:0] fb_y;

  assign in_win = (h >= coord_t'(WIN_X0)) &&
                  (h <  coord_t'(WIN_X0 + (SCR_WIDTH << SCALE_SHIFT))) &&
                  (v >= coord_t'(WIN_Y0)) &&
                  (v <  coord_t'(WIN_Y0 + (SCR_HEIGHT << SCALE_SHIFT)));
  assign fb_x = XB'((h - coord_t'(WIN_X0)) >> SCALE_SHIFT);
  assign fb_y = YB'((v - coord_t'(WIN_Y0)) >> SCALE_SHIFT);

  // Forced to 0 outside the window so the address bus is deterministic.
  assign mem_address = in_win ? MEMORY_SIZE_BITS'(`MAP_PIXELCO_MEMADDR(fb_x, fb_y)) : '0;

  logic win_s1, active_s1, hsync_s1, vsync_s1, frame_s1;

  // Frame pulse fires on the first Clck of (0, V_ACTIVE) only, hence the phase term.
  always_ff @(posedge Clck) begin
    if (Reset) begin
      win_s1    <= 1'b0;
      active_s1 <= 1'b0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      frame_s1  <= 1'b0;
    end else begin
      win_s1    <= in_win;
      active_s1 <= active_raw;
      hsync_s1  <= hsync_raw;
      vsync_s1  <= vsync_raw;
      frame_s1  <= (h == '0) && (v == coord_t'(V_ACTIVE)) && !phase;
    end
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_color   <= COLOR_BLACK;
      frame_done  <= 1'b0;
    end else begin
      vga_hs      <= ~hsync_s1;
      vga_vs      <= ~vsync_s1;
      vga_blank_n <= active_s1;
      frame_done  <= frame_s1;
      if (!active_s1)
        vga_color <= COLOR_BLACK;
      else if (win_s1)
        vga_color <= mem_q;
      else
        vga_color <= BORDER_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: an independent scan model predicts every
// output cycle, plus spot checks of line timing, address mapping and frame pulses.
module tb_vga_frame_reader;

  localparam logic [2:0] BORDER = 3'b000;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [2:0] col;
    logic       fd;
  } out_t;

  localparam out_t RST_OUT = out_t'(7'b1100000);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] mem_address;
  logic [2:0]  mem_q = 3'd0;
  logic [2:0]  vga_color;
  logic        vga_hs, vga_vs, vga_blank_n, frame_done;

  always #10 clk = ~clk;

  vga_frame_reader #(
    .SCR_WIDTH        (128),
    .SCR_HEIGHT       (96),
    .MEMORY_SIZE_BITS (14),
    .BORDER_COLOR     (BORDER)
  ) dut (
    .Clck        (clk),
    .Reset       (rst),
    .mem_address (mem_address),
    .mem_q       (mem_q),
    .vga_color   (vga_color),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_done  (frame_done)
  );

  // Synchronous-read memory whose contents are the low address bits.
  always @(posedge clk) mem_q <= mem_address[2:0];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int exp_addr(input int h, input int v);
    if (h >= 64 && h < 576 && v >= 48 && v < 432)
      return ((v - 48) / 4) * 128 + (h - 64) / 4;
    return 0;
  endfunction

  function automatic out_t exp_out(input int h, input int v, input bit ph);
    out_t o;
    bit   act, win;
    int   a;
    act     = (h < 640) && (v < 480);
    win     = (h >= 64 && h < 576 && v >= 48 && v < 432);
    a       = exp_addr(h, v);
    o.hs    = !(h >= 656 && h < 752);
    o.vs    = !(v >= 490 && v < 492);
    o.blank = act;
    o.col   = !act ? 3'd0 : (win ? 3'(a % 8) : BORDER);
    o.fd    = (h == 0 && v == 480 && !ph);
    return o;
  endfunction

  out_t sbq[$];
  int   mh = 0, mv = 0;
  bit   mph = 1'b0;
  int   dh1 = 0, dv1 = 0, dh2 = 0, dv2 = 0;
  int   cyc = 0, rel_cyc = 0, last_fd = -1, t_brise = -1, t_hfall = -1;
  int   fd_count = 0;
  bit   started = 1'b0, lat_pend = 1'b0;
  bit   line_done = 1'b0, hs_done = 1'b0, hsw_done = 1'b0;
  logic pb = 1'b0, phs = 1'b1;

  always @(posedge clk) begin
    bit   r;
    out_t outs;
    out_t e;
    r   = rst;
    dh2 = dh1; dv2 = dv1;
    dh1 = mh;  dv1 = mv;
    if (r) begin
      mh = 0; mv = 0; mph = 1'b0;
    end else begin
      if (mph) begin
        if (mh == 799) begin
          mh = 0;
          mv = (mv == 524) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      mph = !mph;
    end
    #1;
    cyc++;
    outs = {vga_hs, vga_vs, vga_blank_n, vga_color, frame_done};
    if (r) begin
      started  = 1'b1;
      rel_cyc  = cyc;
      lat_pend = 1'b1;
      last_fd  = -1;
      check("reset_out", int'(outs), int'(RST_OUT));
      check("reset_addr", int'(mem_address), 0);
      sbq.delete();
      sbq.push_back(RST_OUT);
      sbq.push_back(exp_out(0, 0, 1'b0));
    end else if (started) begin
      e = sbq.pop_front();
      check("out", int'(outs), int'(e));
      check("addr", int'(mem_address), exp_addr(mh, mv));
      sbq.push_back(exp_out(mh, mv, mph));

      if (!mph && mh == 64  && mv == 48)  check("addr_64_48",   int'(mem_address), 0);
      if (!mph && mh == 68  && mv == 48)  check("addr_68_48",   int'(mem_address), 1);
      if (!mph && mh == 64  && mv == 52)  check("addr_64_52",   int'(mem_address), 128);
      if (!mph && mh == 575 && mv == 431) check("addr_575_431", int'(mem_address), 12287);
      if (dh2 == 10  && dv2 == 10)  check("border_10_10",  int'(vga_color), int'(BORDER));
      if (dh2 == 700 && dv2 == 100) check("color_h700",    int'(vga_color), 0);
      if (dh2 == 100 && dv2 == 60)  check("color_100_60",  int'(vga_color), 1);

      if (vga_blank_n && !pb) begin
        if (lat_pend) begin
          check("blank_latency", cyc - rel_cyc, 2);
          lat_pend = 1'b0;
        end
        if (t_brise >= 0 && !line_done) begin
          check("line_period", cyc - t_brise, 1600);
          line_done = 1'b1;
        end
        t_brise = cyc;
      end
      if (!vga_hs && phs) begin
        if (!hs_done) begin
          check("blank_to_hs", cyc - t_brise, 1312);
          hs_done = 1'b1;
        end
        t_hfall = cyc;
      end
      if (vga_hs && !phs && !hsw_done && t_hfall >= 0) begin
        check("hs_width", cyc - t_hfall, 192);
        hsw_done = 1'b1;
      end

      if (frame_done) begin
        fd_count++;
        check("fd_blank", int'(vga_blank_n), 0);
        check("fd_v", dv2, 480);
        if (last_fd >= 0) check("frame_period", cyc - last_fd, 840000);
        else              check("fd_after_release", cyc - rel_cyc, 480 * 1600 + 2);
        last_fd = cyc;
      end
    end
    pb  = vga_blank_n;
    phs = vga_hs;
  end

  initial begin
    int n0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 400000 && mv != 200; i++) @(negedge clk);
    check("reach_v200", int'(mv == 200), 1);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    n0 = fd_count;
    for (int i = 0; i < 800000 && fd_count == n0; i++) @(negedge clk);
    check("first_fd_seen", int'(fd_count > n0), 1);

    n0 = fd_count;
    for (int i = 0; i < 850000 && fd_count == n0; i++) @(negedge clk);
    check("second_fd_seen", int'(fd_count > n0), 1);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
